// File: rtl/writeback_regfile.sv
`default_nettype none
//============================================================================
// Module   : writeback_regfile
// Purpose  : 32-entry integer register file for the multicycle RISC-V core,
//            plus the write-back sequencer that owns every write into it.
//            Two combinational read ports feed the A/B operand registers;
//            a three-state FSM (IDLE -> COMMIT -> DONE) captures the selected
//            result and commits it to rd.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            rs1, rs2             - read addresses
//            rs1_dout, rs2_dout   - combinational read data (x0 reads 0)
//            wb_start             - write-back request, sampled in IDLE only
//            wb_src               - 0 ALUOut, 1 MDR, 2 PC+4, 3 -> ALUOut
//            wb_rd, wb_reg_write  - destination register and write enable
//            alu_out, mdr, pc_plus4 - candidate result values
//            wb_busy              - high whenever the FSM is not IDLE
//            wb_done              - one-cycle pulse, new value already readable
//            x17_value            - live contents of x17 (ecall halt detect)
// Revision : 1.0 - initial release
//============================================================================
module writeback_regfile #(
   parameter int                    data_width = 32,
   parameter logic [data_width-1:0] sp_init    = 32'h00002ffc
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   output logic [data_width-1:0] rs1_dout,
   output logic [data_width-1:0] rs2_dout,
   input  logic                  wb_start,
   input  logic [1:0]            wb_src,
   input  logic [4:0]            wb_rd,
   input  logic                  wb_reg_write,
   input  logic [data_width-1:0] alu_out,
   input  logic [data_width-1:0] mdr,
   input  logic [data_width-1:0] pc_plus4,
   output logic                  wb_busy,
   output logic                  wb_done,
   output logic [data_width-1:0] x17_value
);

   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_MDR = 2'd1;
   localparam logic [1:0] SRC_PC4 = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COMMIT = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [data_width-1:0]   regs [32];
   logic [data_width-1:0]   wb_data;
   logic [4:0]              lat_rd;
   logic                    lat_we;
   logic [data_width-1:0]   src_sel;
   logic                    accept;
   logic                    do_write;

   //------------------------------------------------------------------------
   // Result source select; the reserved encoding falls back to ALUOut.
   //------------------------------------------------------------------------
   always_comb begin
      src_sel = alu_out;
      case (wb_src)
         SRC_ALU: src_sel = alu_out;
         SRC_MDR: src_sel = mdr;
         SRC_PC4: src_sel = pc_plus4;
         default: src_sel = alu_out;
      endcase
   end

   //------------------------------------------------------------------------
   // FSM: state register and next-state logic
   //------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (wb_start) begin
               accept     = 1'b1;
               state_next = COMMIT;
            end
         end
         COMMIT:  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Status flags come straight from the state register, so they carry no
   // combinational path from any input.
   assign wb_busy = (state != IDLE);
   assign wb_done = (state == DONE);

   //------------------------------------------------------------------------
   // Request capture: the in-flight write is frozen at the accepting edge,
   // so the sources are free to change afterwards.
   //------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_data <= '0;
         lat_rd  <= '0;
         lat_we  <= 1'b0;
      end else if (accept) begin
         wb_data <= src_sel;
         lat_rd  <= wb_rd;
         lat_we  <= wb_reg_write;
      end
   end

   //------------------------------------------------------------------------
   // Storage. Writes to x0 are dropped here; reset has priority over a
   // pending commit.
   //------------------------------------------------------------------------
   assign do_write = (state == COMMIT) && lat_we && (lat_rd != 5'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= (i == 2) ? sp_init : '0;
         end
      end else if (do_write) begin
         regs[lat_rd] <= wb_data;
      end
   end

   // No write-to-read bypass: a read of lat_rd during COMMIT sees the old
   // value, and the new one appears once the edge into DONE has written it.
   assign rs1_dout  = (rs1 == 5'd0) ? '0 : regs[rs1];
   assign rs2_dout  = (rs2 == 5'd0) ? '0 : regs[rs2];
   assign x17_value = regs[17];

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
//============================================================================
// Module   : tb_writeback_regfile
// Purpose  : Self-checking bench for writeback_regfile. Stimulus pushes the
//            expected read-port value and wb_done cycle for every request;
//            a monitor pops and compares whenever wb_done is seen.
// Revision : 1.0 - initial release
//============================================================================
module tb_writeback_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1, rs2;
   logic [31:0] rs1_dout, rs2_dout;
   logic        wb_start;
   logic [1:0]  wb_src;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic [31:0] alu_out, mdr, pc_plus4;
   logic        wb_busy, wb_done;
   logic [31:0] x17_value;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] val;
      int          cyc;
   } exp_t;
   exp_t sbq[$];

   writeback_regfile dut (
      .clk          (clk),
      .reset        (reset),
      .rs1          (rs1),
      .rs2          (rs2),
      .rs1_dout     (rs1_dout),
      .rs2_dout     (rs2_dout),
      .wb_start     (wb_start),
      .wb_src       (wb_src),
      .wb_rd        (wb_rd),
      .wb_reg_write (wb_reg_write),
      .alu_out      (alu_out),
      .mdr          (mdr),
      .pc_plus4     (pc_plus4),
      .wb_busy      (wb_busy),
      .wb_done      (wb_done),
      .x17_value    (x17_value)
   );

   always #5 clk = ~clk;

   // Edge counter: at a negedge, cyc equals the number of rising edges so far.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every wb_done must match the head of the scoreboard, both in
   // timing and in the value visible on both read ports.
   always @(negedge clk) begin
      if (wb_done === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", 32'(cyc), 32'hFFFFFFFF);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("done_rs1", rs1_dout, e.val);
            chk("done_rs2", rs2_dout, e.val);
         end
      end
   end

   // Called at a negedge with the DUT idle; the next rising edge accepts.
   task automatic issue(input logic [1:0] src, input logic [31:0] a, input logic [31:0] m,
                        input logic [31:0] p, input logic [4:0] rd, input logic we,
                        input logic [4:0] rdreg, input logic [31:0] expv);
      exp_t e;
      wb_src = src; alu_out = a; mdr = m; pc_plus4 = p;
      wb_rd = rd; wb_reg_write = we; rs1 = rdreg; rs2 = rdreg;
      wb_start = 1'b1;
      e.val = expv;
      e.cyc = cyc + 2;
      sbq.push_back(e);
   endtask

   // Change every source after acceptance; the in-flight write must not care.
   task automatic scramble();
      alu_out = $urandom; mdr = $urandom; pc_plus4 = $urandom;
      wb_src = 2'($urandom); wb_rd = 5'($urandom); wb_reg_write = 1'($urandom);
   endtask

   // Accept at the next edge, drop wb_start, scramble, wait until IDLE again.
   task automatic run_simple(input logic [1:0] src, input logic [31:0] a, input logic [31:0] m,
                             input logic [31:0] p, input logic [4:0] rd, input logic we,
                             input logic [4:0] rdreg, input logic [31:0] expv);
      issue(src, a, m, p, rd, we, rdreg, expv);
      @(negedge clk);
      wb_start = 1'b0;
      scramble();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      exp_t e;
      reset = 1'b1; wb_start = 1'b0; wb_src = 2'd0; wb_rd = 5'd0; wb_reg_write = 1'b0;
      alu_out = '0; mdr = '0; pc_plus4 = '0; rs1 = 5'd0; rs2 = 5'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset contents of the whole file, through both ports.
      chk("reset_busy", 32'(wb_busy), 32'd0);
      chk("reset_done", 32'(wb_done), 32'd0);
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i);
         rs2 = 5'(31 - i);
         #1;
         chk($sformatf("reset_x%0d", i), rs1_dout, (i == 2) ? 32'h00002ffc : 32'h0);
         chk($sformatf("reset_p2_x%0d", 31 - i), rs2_dout, ((31 - i) == 2) ? 32'h00002ffc : 32'h0);
      end
      @(negedge clk);

      // Single ALUOut write to x5 with timing of busy/done/old value.
      issue(2'd0, 32'hDEADBEEF, 32'h11111111, 32'h22222222, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF);
      chk("idle_busy", 32'(wb_busy), 32'd0);
      @(negedge clk);                       // COMMIT
      wb_start = 1'b0;
      scramble();
      chk("commit_old_x5", rs1_dout, 32'h0);
      chk("commit_busy", 32'(wb_busy), 32'd1);
      chk("commit_done", 32'(wb_done), 32'd0);
      @(negedge clk);                       // DONE (monitor checks value)
      chk("done_busy", 32'(wb_busy), 32'd1);
      @(negedge clk);                       // IDLE
      chk("after_busy", 32'(wb_busy), 32'd0);
      chk("after_done", 32'(wb_done), 32'd0);
      chk("after_x5", rs1_dout, 32'hDEADBEEF);

      // Back-to-back with wb_start held: MDR then PC+4 into x10.
      issue(2'd1, 32'hAAAA0000, 32'h12345678, 32'h0, 5'd10, 1'b1, 5'd10, 32'h12345678);
      @(negedge clk);                       // first COMMIT; set up second request
      wb_src = 2'd2; pc_plus4 = 32'h00000104; mdr = 32'hBAD0BAD0; alu_out = 32'hBAD1BAD1;
      wb_rd = 5'd10; wb_reg_write = 1'b1;
      e.val = 32'h00000104;
      e.cyc = cyc + 4;                      // second accept lands 3 edges after the first
      sbq.push_back(e);
      repeat (2) @(negedge clk);            // first DONE, then IDLE (accepting edge next)
      chk("b2b_idle_gap", 32'(wb_busy), 32'd0);
      @(negedge clk);                       // second COMMIT
      wb_start = 1'b0;
      scramble();
      chk("b2b_commit_old", rs1_dout, 32'h12345678);
      repeat (2) @(negedge clk);
      chk("b2b_final_x10", rs2_dout, 32'h00000104);

      // Write to x0 is dropped.
      run_simple(2'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 1'b1, 5'd0, 32'h0);

      // Reserved source encoding selects ALUOut; also seeds x7.
      run_simple(2'd3, 32'h00000077, 32'hBBBBBBBB, 32'hCCCCCCCC, 5'd7, 1'b1, 5'd7, 32'h00000077);

      // wb_reg_write=0 leaves x7 untouched but still pulses done.
      run_simple(2'd0, 32'h0000AAAA, 32'h0, 32'h0, 5'd7, 1'b0, 5'd7, 32'h00000077);

      // x17 tracking.
      issue(2'd0, 32'd10, 32'h0, 32'h0, 5'd17, 1'b1, 5'd17, 32'd10);
      @(negedge clk);
      wb_start = 1'b0;
      scramble();
      chk("x17_commit_old", x17_value, 32'd0);
      @(negedge clk);
      chk("x17_done", x17_value, 32'd10);
      @(negedge clk);

      // Reset during COMMIT: no write, everything back to reset values.
      wb_src = 2'd0; alu_out = 32'h55; wb_rd = 5'd3; wb_reg_write = 1'b1;
      rs1 = 5'd3; rs2 = 5'd2;
      wb_start = 1'b1;                      // not pushed: no done expected
      @(negedge clk);                       // COMMIT
      wb_start = 1'b0;
      chk("rst_commit_busy", 32'(wb_busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_x3", rs1_dout, 32'h0);
      chk("rst_x2", rs2_dout, 32'h00002ffc);
      chk("rst_x17", x17_value, 32'h0);
      chk("rst_busy", 32'(wb_busy), 32'd0);
      chk("rst_done", 32'(wb_done), 32'd0);
      repeat (3) @(negedge clk);
      chk("rst_x3_later", rs1_dout, 32'h0);
      chk("rst_idle_busy", 32'(wb_busy), 32'd0);
      rs1 = 5'd10;
      #1;
      chk("rst_x10", rs1_dout, 32'h0);

      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
